// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant with an IDLE gap on every hand-off,
// combinational bus steering and a per-transfer strobe timeout that raises m_err.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  m_cyc,
  input  logic [1:0]  m_stb,
  input  logic [1:0]  m_we,
  input  logic [7:0]  m_sel,
  input  logic [63:0] m_adr,
  input  logic [63:0] m_dat_w,
  output logic [1:0]  m_ack,
  output logic [1:0]  m_err,
  output logic [31:0] m_dat_r,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_w,
  input  logic        s_ack,
  input  logic [31:0] s_dat_r,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    G0   = 3'b010,
    G1   = 3'b100
  } state_e;

  localparam logic        TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic        gsel;
  logic        granted;
  logic        stb_raw;
  logic        tmo_hit;
  logic        ack_g;

  // Arbitration: last_q records the most recently granted master (1 after reset).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m_cyc[0] && (!m_cyc[1] || last_q)) state_d = G0;
        else if (m_cyc[1])                     state_d = G1;
      end
      G0: begin
        if (!m_cyc[0]) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      G1: begin
        if (!m_cyc[1]) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == G1, state_d == G0};
  end

  // Bus steering from the registered grant.
  always_comb begin
    gsel    = grant_q[1];
    granted = |grant_q;
    s_cyc   = granted & m_cyc[gsel];
    stb_raw = granted & m_stb[gsel];
    s_we    = granted & m_we[gsel];
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    if (granted) begin
      s_sel   = gsel ? m_sel[7:4]     : m_sel[3:0];
      s_adr   = gsel ? m_adr[63:32]   : m_adr[31:0];
      s_dat_w = gsel ? m_dat_w[63:32] : m_dat_w[31:0];
    end
    // Ack has priority: a coinciding s_ack suppresses the timeout.
    tmo_hit = TMO_EN && s_cyc && stb_raw && !s_ack && (cnt_q == TMO_LAST);
    s_stb   = stb_raw & ~tmo_hit;
    ack_g   = s_ack & s_cyc;
    m_ack   = {gsel & ack_g, ~gsel & ack_g};
    m_err   = {gsel & tmo_hit, ~gsel & tmo_hit};
    m_dat_r = s_dat_r;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || !stb_raw || s_ack || tmo_hit) cnt_d = '0;
    else if (s_cyc)                                         cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Vector-table bench for wb_arbiter (TIMEOUT = 4): each row is driven one cycle and its
// expected outputs are queued, then popped and compared on the following falling edge.
module tb_wb_arbiter;

  localparam logic [31:0] ADR0 = 32'h1000_00A0;
  localparam logic [31:0] ADR1 = 32'h2000_00B4;
  localparam logic [31:0] DW0  = 32'hCAFE_0000;
  localparam logic [31:0] DW1  = 32'hBEEF_1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_cyc = '0, m_stb = '0;
  logic [1:0]  m_we = 2'b01;
  logic [7:0]  m_sel = 8'h5F;
  logic [63:0] m_adr = {ADR1, ADR0};
  logic [63:0] m_dat_w = {DW1, DW0};
  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_dat_r, s_adr, s_dat_w;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic        s_ack = 1'b0;
  logic [31:0] s_dat_r = '0;

  wb_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_ack(s_ack), .s_dat_r(s_dat_r), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic [1:0]  cyc, stb;
    logic        ack;
    logic [31:0] rdat;
    logic [1:0]  g, k, e;
    logic        sc, ss;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic [1:0] c, s,
                              input logic a, input logic [1:0] g, k, e, input logic sc, ss);
    vec_t v;
    v.nm = nm; v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.rdat = '0;
    v.g = g; v.k = k; v.e = e; v.sc = sc; v.ss = ss;
    return v;
  endfunction

  task automatic chk(input string nm, input string what, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", nm, what, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [31:0] ea, ed, es;
      cur = sb.pop_front();
      ea = (cur.g == 2'b01) ? ADR0 : (cur.g == 2'b10) ? ADR1 : 32'h0;
      ed = (cur.g == 2'b01) ? DW0  : (cur.g == 2'b10) ? DW1  : 32'h0;
      es = (cur.g == 2'b01) ? 32'hF : (cur.g == 2'b10) ? 32'h5 : 32'h0;
      chk(cur.nm, "grant",   32'(grant),  32'(cur.g));
      chk(cur.nm, "m_ack",   32'(m_ack),  32'(cur.k));
      chk(cur.nm, "m_err",   32'(m_err),  32'(cur.e));
      chk(cur.nm, "s_cyc",   32'(s_cyc),  32'(cur.sc));
      chk(cur.nm, "s_stb",   32'(s_stb),  32'(cur.ss));
      chk(cur.nm, "s_we",    32'(s_we),   32'(cur.g == 2'b01));
      chk(cur.nm, "s_sel",   32'(s_sel),  es);
      chk(cur.nm, "s_adr",   s_adr,       ea);
      chk(cur.nm, "s_dat_w", s_dat_w,     ed);
      chk(cur.nm, "m_dat_r", m_dat_r,     cur.rdat);
    end
  end

  initial begin
    // name rst cyc stb ack | grant m_ack m_err s_cyc s_stb
    vecs.push_back(mk("rst",      0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rst_rel",  1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("m0_req",   1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("m0_stb1",  1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("m0_stb2",  1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("m0_ack",   1, 2'b01, 2'b01, 1, 2'b01, 2'b01, 2'b00, 1, 1));
    vecs.push_back(mk("m0_drop",  1, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("m0_idle",  1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_rst",   0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_rel",   1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c0",    1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c1",    1, 2'b11, 2'b11, 1, 2'b01, 2'b01, 2'b00, 1, 1));
    vecs.push_back(mk("rr_c2",    1, 2'b10, 2'b10, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c3",    1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c4",    1, 2'b11, 2'b11, 1, 2'b10, 2'b10, 2'b00, 1, 1));
    vecs.push_back(mk("rr_c5",    1, 2'b01, 2'b01, 0, 2'b10, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c6",    1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c7",    1, 2'b11, 2'b11, 1, 2'b01, 2'b01, 2'b00, 1, 1));
    vecs.push_back(mk("rr_c8",    1, 2'b10, 2'b10, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c9",    1, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c10",   1, 2'b11, 2'b11, 1, 2'b10, 2'b10, 2'b00, 1, 1));
    vecs.push_back(mk("rr_c11",   1, 2'b01, 2'b01, 0, 2'b10, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("rr_c12",   1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("hold_d0",  1, 2'b10, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("hold_d1",  1, 2'b11, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("hold_d2",  1, 2'b11, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("hold_d3",  1, 2'b11, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("hold_d4",  1, 2'b01, 2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("hold_d5",  1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("hold_d6",  1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("hold_d7",  1, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("hold_d8",  1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("tmo_e0",   1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("tmo_e1",   1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("tmo_e2",   1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("tmo_e3",   1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("tmo_e4",   1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b01, 1, 0));
    vecs.push_back(mk("tmo_e5",   1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("tmo_e6",   1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk("tmo_e7",   1, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("tmo_e8",   1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("race_f0",  1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("race_f1",  1, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("race_f2",  1, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("race_f3",  1, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("race_f4",  1, 2'b10, 2'b10, 1, 2'b10, 2'b10, 2'b00, 1, 1));
    vecs.push_back(mk("race_f5",  1, 2'b00, 2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("idle_ack", 1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mrst_g0",  1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mrst_g1",  1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("mrst_g2",  0, 2'b01, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mrst_g3",  1, 2'b01, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mrst_g4",  1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk("mrst_g5",  1, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk("mrst_g6",  1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      v.rdat = $urandom;
      @(posedge clk);
      #1;
      rst_n   = v.rst;
      m_cyc   = v.cyc;
      m_stb   = v.stb;
      s_ack   = v.ack;
      s_dat_r = v.rdat;
      sb.push_back(v);
    end

    for (int n = 0; n < 5 && sb.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
